// File: rtl/cpu_pkg.sv
// Shared CPU definitions: loader FSM states and instruction memory size.
// Imported by the boot loader and by cpu_instrmem.
package cpu_pkg;

    // 64 KB of 32-bit words in cpu_instrmem
    localparam int IMEM_MAX_WORDS = 16384;

    typedef enum logic [2:0] {
        IDLE,
        LEN_LO,
        LEN_HI,
        DATA,
        CKSUM,
        DONE,
        ERR
    } ldr_state_e;

endpackage

// File: rtl/cpu_loader_wordpack.sv
// Byte-to-word packer for the imem loader: 2-bit byte counter, LE shift
// register, running XOR of payload bytes and a registered word_rdy pulse.
// Ports: clk, rst_n, byte_en/byte_in (accepted payload byte), last_byte
// (next byte completes a word), word, word_rdy, xsum.
module cpu_loader_wordpack (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic        last_byte,
    output logic [31:0] word,
    output logic        word_rdy,
    output logic [7:0]  xsum
);

    logic [1:0]  cnt;
    logic [31:0] sh;

    assign last_byte = (cnt == 2'd3);
    assign word      = sh;

    // Bytes enter at the top and shift down, so after four bytes the
    // first one sits in [7:0]. word_rdy fires the cycle after the 4th
    // byte, when sh holds the whole word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= 2'd0;
            sh       <= 32'd0;
            xsum     <= 8'd0;
            word_rdy <= 1'b0;
        end else begin
            word_rdy <= byte_en && last_byte;
            if (byte_en) begin
                cnt  <= cnt + 2'd1;
                sh   <= {byte_in, sh[31:8]};
                xsum <= xsum ^ byte_in;
            end
        end
    end

endmodule

// File: rtl/cpu_imem_loader.sv
// Boot loader: fills cpu_instrmem from a host byte stream (len16, payload,
// xor checksum) and holds the core in reset until the image verifies.
// Ports: clk, rst_n, in_valid/in_data/in_ready (host bytes), mem_we,
// mem_addr, mem_wdata (imem write), loaded_words, done, err, cpu_rst_n.
module cpu_imem_loader
    import cpu_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter int                MAX_WORDS = IMEM_MAX_WORDS,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [15:0]       loaded_words,
    output logic              done,
    output logic              err,
    output logic              cpu_rst_n
);

    ldr_state_e  state;
    ldr_state_e  state_nxt;

    logic        acc;
    logic        pay_en;
    logic [7:0]  len_lo;
    logic [15:0] len;
    logic [15:0] len_full;
    logic [15:0] wcnt;
    logic        last_byte;
    logic        word_rdy;
    logic [31:0] word;
    logic [7:0]  xsum;
    logic        last_word;

    assign acc      = in_valid && in_ready;
    assign pay_en   = acc && (state == DATA);
    assign len_full = {in_data, len_lo};
    // len >= 1 whenever we are in DATA
    assign last_word = (wcnt == len - 16'd1);

    cpu_loader_wordpack u_pack (
        .clk       (clk),
        .rst_n     (rst_n),
        .byte_en   (pay_en),
        .byte_in   (in_data),
        .last_byte (last_byte),
        .word      (word),
        .word_rdy  (word_rdy),
        .xsum      (xsum)
    );

    assign mem_we    = word_rdy;
    assign mem_wdata = word;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        unique case (state)
            IDLE: begin
                state_nxt = LEN_LO;
            end
            LEN_LO: begin
                in_ready = 1'b1;
                if (acc) state_nxt = LEN_HI;
            end
            LEN_HI: begin
                in_ready = 1'b1;
                if (acc) begin
                    if ({1'b0, len_full} > 17'(MAX_WORDS))
                        state_nxt = ERR;
                    else if (len_full == 16'd0)
                        state_nxt = CKSUM;
                    else
                        state_nxt = DATA;
                end
            end
            DATA: begin
                in_ready = 1'b1;
                if (pay_en && last_byte && last_word)
                    state_nxt = CKSUM;
            end
            CKSUM: begin
                in_ready = 1'b1;
                if (acc)
                    state_nxt = (in_data == xsum) ? DONE : ERR;
            end
            DONE: state_nxt = DONE;
            ERR:  state_nxt = ERR;
            default: state_nxt = ERR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_lo <= 8'd0;
            len    <= 16'd0;
            wcnt   <= 16'd0;
        end else begin
            if (acc && state == LEN_LO) len_lo <= in_data;
            if (acc && state == LEN_HI) len    <= len_full;
            if (pay_en && last_byte)    wcnt   <= wcnt + 16'd1;
        end
    end

    // Address and count advance after the write so that during mem_we
    // they reflect the word being written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr     <= BASE_ADDR;
            loaded_words <= 16'd0;
        end else if (mem_we) begin
            mem_addr     <= mem_addr + ADDR_W'(4);
            loaded_words <= loaded_words + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done      <= 1'b0;
            err       <= 1'b0;
            cpu_rst_n <= 1'b0;
        end else begin
            done      <= (state_nxt == DONE);
            err       <= (state_nxt == ERR);
            cpu_rst_n <= (state_nxt == DONE);
        end
    end

endmodule

// File: tb/tb_cpu_imem_loader.sv
// Scoreboard bench for cpu_imem_loader: expected imem writes queued as
// bytes are driven, popped and compared on each mem_we.
module tb_cpu_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'd0;
    logic        in_ready;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [15:0] loaded_words;
    logic        done;
    logic        err;
    logic        cpu_rst_n;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;
    logic [15:0] exp_addr;
    logic [7:0]  cs;
    logic [47:0] exp_q[$];

    always #5 clk = ~clk;

    cpu_imem_loader dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_data      (in_data),
        .in_ready     (in_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .loaded_words (loaded_words),
        .done         (done),
        .err          (err),
        .cpu_rst_n    (cpu_rst_n)
    );

    task automatic chk(input string tag, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && mem_we) begin
            wr_cnt++;
            if (exp_q.size() == 0) begin
                chk("unexp_we", {mem_addr, mem_wdata}, 64'd0);
            end else begin
                logic [47:0] e;
                e = exp_q.pop_front();
                chk("wr", {16'd0, mem_addr, mem_wdata}, {16'd0, e});
            end
        end
    end

    task automatic do_reset();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst", {in_ready, mem_we, mem_addr, mem_wdata, loaded_words,
                    done, err, cpu_rst_n},
            {1'b0, 1'b0, 16'h0000, 32'd0, 16'd0, 1'b0, 1'b0, 1'b0});
        exp_q.delete();
        exp_addr = 16'h0000;
        cs = 8'd0;
        wr_cnt = 0;
        rst_n = 1'b1;
    endtask

    // Called at a negedge; returns at the negedge after the transfer.
    task automatic send(input logic [7:0] b);
        int t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            chk("rdy_timeout", 0, 1);
        end else begin
            in_valid = 1'b1;
            in_data  = b;
            @(negedge clk);
            in_valid = 1'b0;
        end
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        exp_q.push_back({exp_addr, w});
        exp_addr = exp_addr + 16'd4;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            b = w[8*i +: 8];
            cs = cs ^ b;
            send(b);
            if (gap > 0) repeat ($urandom_range(gap, gap + 3)) @(negedge clk);
        end
    endtask

    task automatic finish(input string tag, input logic d, input logic e,
                          input logic [15:0] lw, input int nw);
        int t = 0;
        while (!(done || err) && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_end_to"}, (done || err), 1);
        @(negedge clk);
        #1;
        chk({tag, "_stat"}, {done, err, cpu_rst_n, in_ready}, {d, e, d, 1'b0});
        chk({tag, "_lw"}, loaded_words, lw);
        chk({tag, "_nwr"}, wr_cnt, nw);
        chk({tag, "_q"}, exp_q.size(), 0);
    endtask

    initial begin
        // N=2 basic image
        do_reset();
        send(8'h02); send(8'h00);
        send_word(32'h44332211, 0);
        send_word(32'h88776655, 0);
        chk("t1_cs", cs, 8'h88);
        send(cs);
        finish("t1", 1'b1, 1'b0, 16'd2, 2);

        // N=0, good checksum
        do_reset();
        send(8'h00); send(8'h00); send(8'h00);
        finish("t2a", 1'b1, 1'b0, 16'd0, 0);

        // N=0, bad checksum
        do_reset();
        send(8'h00); send(8'h00); send(8'h01);
        finish("t2b", 1'b0, 1'b1, 16'd0, 0);

        // Oversize length
        do_reset();
        send(8'h01); send(8'h40);
        #1;
        chk("t3_imm", {err, in_ready, done}, {1'b1, 1'b0, 1'b0});
        repeat (5) @(negedge clk);
        finish("t3", 1'b0, 1'b1, 16'd0, 0);

        // N=1 with gaps between bytes
        do_reset();
        send(8'h01);
        repeat (4) @(negedge clk);
        send(8'h00);
        repeat (3) @(negedge clk);
        send_word(32'hDEADBEEF, 3);
        send(cs);
        finish("t4", 1'b1, 1'b0, 16'd1, 1);

        // N=3, bad checksum
        do_reset();
        send(8'h03); send(8'h00);
        send_word(32'h01020304, 0);
        send_word(32'hA5A55A5A, 0);
        send_word(32'hCAFEF00D, 0);
        send(cs ^ 8'hFF);
        finish("t5", 1'b0, 1'b1, 16'd3, 3);

        // Reset mid-load, then a fresh N=1 image
        do_reset();
        send(8'h02); send(8'h00);
        send_word(32'h13579BDF, 0);
        send(8'hAA); send(8'hBB);
        repeat (2) @(negedge clk);
        chk("t6_pre", {wr_cnt, loaded_words}, {32'd1, 16'd1});
        do_reset();
        send(8'h01); send(8'h00);
        send_word(32'h0BADC0DE, 0);
        send(cs);
        finish("t6", 1'b1, 1'b0, 16'd1, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
